// File: rtl/avl_bus_pkg.sv
// Shared types and constants for the Avalon-MM single-master decoder.
// Latency: n/a (types only).
// Backpressure: n/a.
package avl_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Target ids 0..7 are real slaves, id NUM_SLAVES (max 8) is the decode-error sink.
    localparam int TGT_W   = 4;
    // Wide enough for any burstcount width this block is built with.
    localparam int BEATS_W = 16;

    typedef struct packed {
        logic [TGT_W-1:0]   target;
        logic               is_write;
        logic [BEATS_W-1:0] beats;
    } txn_entry_t;

    // Avalon treats a burstcount of zero as a single beat.
    function automatic logic [BEATS_W-1:0] eff_beats(input logic [BEATS_W-1:0] bc);
        return (bc == '0) ? BEATS_W'(1) : bc;
    endfunction

endpackage

// File: rtl/avl_bus_if.sv
// Master-side and slave-side Avalon-MM signals around the decoder.
// Latency: n/a (wiring only).
// Backpressure: waitrequest on both sides, no credits.
interface avl_bus_if #(
    parameter int NUM_SLAVES = 2,
    parameter int BURST_W    = 5
);
    // Upstream (CPU) side
    logic [31:0]             m_address;
    logic [31:0]             m_writedata;
    logic [3:0]              m_byteenable;
    logic [BURST_W-1:0]      m_burstcount;
    logic                    m_read;
    logic                    m_write;
    logic                    m_waitrequest;
    logic [31:0]             m_readdata;
    logic                    m_readdatavalid;
    logic                    m_writeresponsevalid;
    logic [1:0]              m_response;

    // Downstream (slave) side
    logic [31:0]             s_address;
    logic [31:0]             s_writedata;
    logic [3:0]              s_byteenable;
    logic [BURST_W-1:0]      s_burstcount;
    logic [NUM_SLAVES-1:0]   s_read;
    logic [NUM_SLAVES-1:0]   s_write;
    logic [NUM_SLAVES-1:0]   s_waitrequest;
    logic [NUM_SLAVES-1:0]   s_readdatavalid;
    logic [NUM_SLAVES-1:0]   s_writeresponsevalid;
    logic [NUM_SLAVES*32-1:0] s_readdata;
    logic [NUM_SLAVES*2-1:0] s_response;

    // Environment view: the CPU issuing commands plus the attached slaves.
    modport master (
        output m_address, m_writedata, m_byteenable, m_burstcount, m_read, m_write,
        input  m_waitrequest, m_readdata, m_readdatavalid, m_writeresponsevalid, m_response,
        input  s_address, s_writedata, s_byteenable, s_burstcount, s_read, s_write,
        output s_waitrequest, s_readdatavalid, s_writeresponsevalid, s_readdata, s_response
    );

    // Interconnect view: slave to the CPU, fan-out to the attached slaves.
    modport slave (
        input  m_address, m_writedata, m_byteenable, m_burstcount, m_read, m_write,
        output m_waitrequest, m_readdata, m_readdatavalid, m_writeresponsevalid, m_response,
        output s_address, s_writedata, s_byteenable, s_burstcount, s_read, s_write,
        input  s_waitrequest, s_readdatavalid, s_writeresponsevalid, s_readdata, s_response
    );

endinterface

// File: rtl/avl_txn_fifo.sv
// Outstanding-transaction FIFO: in-order record of issued commands.
// Latency: push visible at head the next cycle; head/tail read combinationally.
// Backpressure: full/empty flags; a pop in the same cycle makes room for a push at full.
module avl_txn_fifo
    import avl_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  txn_entry_t       push_dat,
    input  logic             pop,
    output txn_entry_t       head_dat,
    output logic [TGT_W-1:0] tail_tgt,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    txn_entry_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] tail_idx;
    logic          wr_en;
    logic          rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign tail_idx = wr_ptr[AW-1:0] - 1'b1;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign tail_tgt = mem[tail_idx].target;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/avl_bus_decoder.sv
// Single-master N-slave Avalon-MM decoder with in-order response routing.
// Latency: zero on command and real-slave response paths; decode errors answer from the cycle after push.
// Backpressure: m_waitrequest = ordering/full stall OR selected slave's waitrequest.
module avl_bus_decoder
    import avl_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES      = 2,
    parameter int                       BURST_W         = 5,
    parameter logic [NUM_SLAVES*32-1:0] BASE_ADDRS      = {32'hFFFE0000, 32'h0},
    parameter logic [NUM_SLAVES*32-1:0] ADDR_MASKS      = {32'hFFFF0000, 32'hFFFFC000},
    parameter int                       MAX_OUTSTANDING = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    avl_bus_if.slave bus,
    output logic     bus_err_o
);

    localparam logic [TGT_W-1:0] DEC_TGT = TGT_W'(NUM_SLAVES);

    logic                  cmd;
    logic [TGT_W-1:0]      dec_tgt;
    logic [TGT_W-1:0]      eff_tgt;
    logic                  stall;
    logic                  slv_wait;
    logic                  wait_d;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [BEATS_W-1:0]    bc_eff;
    logic [NUM_SLAVES-1:0] s_read_d;
    logic [NUM_SLAVES-1:0] s_write_d;

    logic                  lock_vld;
    logic [TGT_W-1:0]      lock_tgt;
    logic [BEATS_W-1:0]    lock_rem;
    logic [BEATS_W-1:0]    beat_cnt;

    txn_entry_t            push_dat;
    txn_entry_t            head;
    logic [TGT_W-1:0]      tail_tgt;
    logic                  full;
    logic                  empty;

    logic                  rsp_rdv;
    logic                  rsp_wrv;
    logic [31:0]           rsp_data;
    logic [1:0]            rsp_code;
    logic                  stray;

    assign cmd    = bus.m_read | bus.m_write;
    assign bc_eff = eff_beats(BEATS_W'(bus.m_burstcount));

    // Broadcast command fields; only the strobes are steered.
    assign bus.s_address    = bus.m_address;
    assign bus.s_writedata  = bus.m_writedata;
    assign bus.s_byteenable = bus.m_byteenable;
    assign bus.s_burstcount = bus.m_burstcount;
    assign bus.s_read       = s_read_d;
    assign bus.s_write      = s_write_d;

    // Address decode: walk from the top so the lowest matching index wins.
    always_comb begin
        dec_tgt = DEC_TGT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_address & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32])
                dec_tgt = TGT_W'(i);
        end
    end

    // Command steering: locked bursts bypass decode and ordering checks.
    always_comb begin
        eff_tgt   = lock_vld ? lock_tgt : dec_tgt;
        stall     = !lock_vld && ((full && !pop) || (!empty && (tail_tgt != dec_tgt)));
        slv_wait  = 1'b0;
        s_read_d  = '0;
        s_write_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (eff_tgt == TGT_W'(i)) begin
                slv_wait = bus.s_waitrequest[i];
                if (!stall) begin
                    s_read_d[i]  = bus.m_read;
                    s_write_d[i] = bus.m_write;
                end
            end
        end
        wait_d = cmd && (stall || slv_wait);
    end

    assign bus.m_waitrequest = wait_d;
    assign accept            = cmd && !wait_d;
    // Write bursts occupy one entry: only the unlocked first beat pushes.
    assign push              = accept && !lock_vld;
    assign push_dat          = '{target:   dec_tgt,
                                 is_write: bus.m_write,
                                 beats:    bus.m_write ? BEATS_W'(1) : bc_eff};

    avl_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .tail_tgt (tail_tgt),
        .full     (full),
        .empty    (empty)
    );

    // Response routing from the head slave; locally generated answers for decode errors.
    always_comb begin
        rsp_rdv  = 1'b0;
        rsp_wrv  = 1'b0;
        rsp_data = '0;
        rsp_code = RESP_OKAY;
        stray    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!empty && (head.target == TGT_W'(i))) begin
                rsp_rdv  = bus.s_readdatavalid[i];
                rsp_wrv  = bus.s_writeresponsevalid[i];
                rsp_data = bus.s_readdata[32*i +: 32];
                rsp_code = bus.s_response[2*i +: 2];
            end else if (bus.s_readdatavalid[i] || bus.s_writeresponsevalid[i]) begin
                stray = 1'b1;
            end
        end
        if (!empty && (head.target == DEC_TGT)) begin
            rsp_code = RESP_DECERR;
            if (!head.is_write)
                rsp_rdv = 1'b1;
            else if (!lock_vld)
                rsp_wrv = 1'b1;
        end
        if (empty)
            pop = 1'b0;
        else if (head.is_write)
            pop = rsp_wrv;
        else
            pop = rsp_rdv && ((beat_cnt + BEATS_W'(1)) == head.beats);
    end

    assign bus.m_readdata           = rsp_data;
    assign bus.m_response           = rsp_code;
    assign bus.m_readdatavalid      = rsp_rdv;
    assign bus.m_writeresponsevalid = rsp_wrv;

    // Beats already returned for the head read; cleared whenever the head retires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            beat_cnt <= '0;
        else if (pop)
            beat_cnt <= '0;
        else if (!empty && !head.is_write && rsp_rdv)
            beat_cnt <= beat_cnt + 1'b1;
    end

    // Write-burst lock: hold the target until the remaining beats are accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_vld <= 1'b0;
            lock_tgt <= '0;
            lock_rem <= '0;
        end else if (accept) begin
            if (lock_vld) begin
                lock_rem <= lock_rem - 1'b1;
                if (lock_rem == BEATS_W'(1)) lock_vld <= 1'b0;
            end else if (bus.m_write && (bc_eff > BEATS_W'(1))) begin
                lock_vld <= 1'b1;
                lock_tgt <= dec_tgt;
                lock_rem <= bc_eff - 1'b1;
            end
        end
    end

    // Sticky protocol error: a response arrived from a slave that does not own the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            bus_err_o <= 1'b0;
        else if (stray)
            bus_err_o <= 1'b1;
    end

endmodule

// File: doc/avl_bus_decoder.md
# avl_bus_decoder

Parametrised single-master, N-slave Avalon-MM interconnect that replaces the wired-OR slave bus in the simulation and FPGA harnesses. It decodes each command against per-slave base/mask windows and asserts read/write only on the selected slave. It routes waitrequest and responses from that slave alone, and keeps responses in order through an outstanding-transaction FIFO. Unmapped addresses receive locally generated DECODEERROR responses instead of hanging the CPU.

## Interface
- NUM_SLAVES, 2: number of slave ports (1..8).
- BURST_W, 5: width of burstcount.
- BASE_ADDRS, {32'hFFFE0000, 32'h0}: NUM_SLAVES×32 packed; slave i base at [32i+:32].
- ADDR_MASKS, {32'hFFFF0000, 32'hFFFFC000}: NUM_SLAVES×32 packed; slave i matches when (addr & mask) == base.
- MAX_OUTSTANDING, 4: response-FIFO depth, power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_address/m_writedata  in  32/32  master command.
- m_byteenable  in  4  byte enables.
- m_burstcount  in  BURST_W  beats, 0 treated as 1.
- m_read / m_write  in  1/1  command strobes, mutually exclusive.
- m_waitrequest  out  1  command stall.
- m_readdata  out  32  read data.
- m_readdatavalid / m_writeresponsevalid  out  1/1  response strobes.
- m_response  out  2  response code.
- s_address/s_writedata/s_byteenable/s_burstcount  out  32/32/4/BURST_W  broadcast copies of master fields.
- s_read / s_write  out  NUM_SLAVES  one-hot per-slave strobes.
- s_waitrequest / s_readdatavalid / s_writeresponsevalid  in  NUM_SLAVES  per-slave status.
- s_readdata / s_response  in  NUM_SLAVES×32 / NUM_SLAVES×2  per-slave response data.
- bus_err_o  out  1  sticky: response seen from a non-head slave, or response with the FIFO empty.

## Operation
- Decode: lowest-index matching slave wins. No match produces target DECERR (id = NUM_SLAVES).
- Acceptance: the cycle where (m_read|m_write) && !m_waitrequest.
- m_waitrequest = stall | s_waitrequest[target]. A DECERR target contributes 0.
- Stall conditions on a first beat:
  - FIFO full.
  - FIFO non-empty and target ≠ target of the most recently pushed entry. This preserves ordering.
- Push on each accepted read, and on the first accepted beat of each write burst. Entry: {target, is_write, beats = burstcount for reads / 1 for writes}.
- Write burst lock:
  - After the first write beat, the remaining burstcount−1 beats go to the locked target with no decode and no stall check.
  - The lock releases after the final beat.
- Head routing:
  - m_readdata/m_response/m_readdatavalid/m_writeresponsevalid mux from s_*[head.target].
  - Strobes from other slaves are dropped and set bus_err_o.
- Read beat count:
  - A head read decrements beats on each readdatavalid.
  - It pops when the count reaches 0.
- A head write pops on writeresponsevalid.
- DECERR head:
  - The block drives response 2'b11, readdata 0.
  - Reads get one readdatavalid per cycle for `beats` cycles.
  - Writes get one writeresponsevalid once the burst lock has released.
- Simultaneous push and pop is allowed at full. Pop frees the slot in the same cycle, so the push proceeds.

## Timing
- Reset values: all outputs 0, FIFO empty, lock cleared, bus_err_o 0.
- Reset mid-burst aborts the burst: all state is discarded and late slave responses are flagged once out of reset.
- Command path (address, data, strobes, waitrequest) is combinational: zero added latency.
- Response path from a real slave is combinational: zero added latency.
- DECERR responses begin the cycle after push at the earliest, provided the entry is at head.
- FIFO count wraps correctly at MAX_OUTSTANDING (pointer width log2+1).

## Structure
- Package avl_bus_pkg holds:
  - RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11.
  - Entry typedef txn_entry_t {target, is_write, beats}.
- Sub-module avl_txn_fifo: synchronous FIFO of txn_entry_t with full/empty, same-cycle push+pop, async reset.
- Decoder and response mux stay in the top level.

## Test plan
- Read 0x00000010 (slave 0), then a read of 0xFFFE0004 issued the next cycle. Required:
  - Second command stalls until the slave-0 readdatavalid.
  - Both data words return in issue order.
- Read burst, burstcount 4, at 0x100. Required: 4 readdatavalid beats from slave 0, FIFO empties after beat 4, s_read[1] never asserted.
- Read of 0x80000000 with burstcount 2. Required: 2 consecutive readdatavalid, m_response 2'b11, readdata 0; no slave strobe asserted.
- Write burst, 3 beats, to slave 1 while slave 1 holds waitrequest for 2 cycles on beat 2. Required:
  - All beats reach s_write[1] only.
  - One writeresponsevalid is routed back.
- Five reads to slave 0 with MAX_OUTSTANDING 4 and no responses. Required: fifth read stalls; first readdatavalid unstalls it in the same cycle.
- Inject s_readdatavalid[1] while the head is slave 0. Required: bus_err_o goes 1 and stays 1; a mid-burst reset clears it to 0.
